// File: rtl/branch_ctrl.sv
// EX-stage branch resolution: computes actual direction/target, flags mispredicts,
// sequences redirect + flush toward fetch, pulses predictor updates and counts events.

module cmp (
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        taken
);
    always_comb begin
        taken = 1'b0;
        case (op)
            3'b000:  taken = (a == b);
            3'b001:  taken = (a != b);
            3'b100:  taken = ($signed(a) <  $signed(b));
            3'b101:  taken = ($signed(a) >= $signed(b));
            3'b110:  taken = (a <  b);
            3'b111:  taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end
endmodule

module branch_ctrl #(
    parameter int CNT_W        = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             stall_in,
    input  logic             ex_is_br,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic [2:0]       ex_cmpop,
    input  logic [31:0]      ex_rs1,
    input  logic [31:0]      ex_rs2,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    input  logic             redirect_ready,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             bp_upd_valid,
    output logic [31:0]      bp_upd_pc,
    output logic             bp_upd_taken,
    output logic [31:0]      bp_upd_target,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);
    typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [2:0]        flush_cnt_q, flush_cnt_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [31:0]       redirect_pc_q, redirect_pc_d;
    logic              flush_q, flush_d;
    logic              bp_upd_valid_q, bp_upd_valid_d;
    logic [31:0]       bp_upd_pc_q, bp_upd_pc_d;
    logic              bp_upd_taken_q, bp_upd_taken_d;
    logic [31:0]       bp_upd_target_q, bp_upd_target_d;
    logic [CNT_W-1:0]  br_count_q, br_count_d;
    logic [CNT_W-1:0]  mispred_count_q, mispred_count_d;

    logic        cmp_taken;
    logic        resolve;
    logic        act_taken;
    logic [31:0] act_target;
    logic [31:0] next_pc;
    logic        mispred;

    cmp u_cmp (
        .op    (ex_cmpop),
        .a     (ex_rs1),
        .b     (ex_rs2),
        .taken (cmp_taken)
    );

    assign resolve    = (state_q == IDLE) & ex_valid & ~stall_in
                      & (ex_is_br | ex_is_jal | ex_is_jalr);
    // Jumps are always taken, so jal/jalr override the comparator for direction.
    assign act_taken  = (ex_is_jalr | ex_is_jal) ? 1'b1 : cmp_taken;
    assign act_target = ex_is_jalr ? ((ex_rs1 + ex_imm) & ~32'h1) : (ex_pc + ex_imm);
    assign next_pc    = act_taken ? act_target : (ex_pc + 32'd4);
    assign mispred    = (ex_pred_taken != act_taken)
                      | (act_taken & (ex_pred_target != act_target));

    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = flush_q;
        bp_upd_valid_d   = 1'b0;
        bp_upd_pc_d      = bp_upd_pc_q;
        bp_upd_taken_d   = bp_upd_taken_q;
        bp_upd_target_d  = bp_upd_target_q;
        br_count_d       = br_count_q;
        mispred_count_d  = mispred_count_q;

        case (state_q)
            IDLE: begin
                if (resolve) begin
                    bp_upd_valid_d  = 1'b1;
                    bp_upd_pc_d     = ex_pc;
                    bp_upd_taken_d  = act_taken;
                    bp_upd_target_d = act_target;
                    if (br_count_q != '1)
                        br_count_d = br_count_q + CNT_W'(1);
                    if (mispred) begin
                        if (mispred_count_q != '1)
                            mispred_count_d = mispred_count_q + CNT_W'(1);
                        redirect_pc_d    = next_pc;
                        redirect_valid_d = 1'b1;
                        flush_d          = 1'b1;
                        state_d          = REDIRECT;
                    end
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    redirect_valid_d = 1'b0;
                    if (FLUSH_CYCLES == 1) begin
                        flush_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        flush_cnt_d = 3'(FLUSH_CYCLES - 1);
                        state_d     = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == 3'd1) begin
                    flush_cnt_d = 3'd0;
                    flush_d     = 1'b0;
                    state_d     = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d          = IDLE;
                flush_d          = 1'b0;
                redirect_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            flush_cnt_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            bp_upd_valid_q   <= 1'b0;
            bp_upd_pc_q      <= '0;
            bp_upd_taken_q   <= 1'b0;
            bp_upd_target_q  <= '0;
            br_count_q       <= '0;
            mispred_count_q  <= '0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            bp_upd_valid_q   <= bp_upd_valid_d;
            bp_upd_pc_q      <= bp_upd_pc_d;
            bp_upd_taken_q   <= bp_upd_taken_d;
            bp_upd_target_q  <= bp_upd_target_d;
            br_count_q       <= br_count_d;
            mispred_count_q  <= mispred_count_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign bp_upd_valid   = bp_upd_valid_q;
    assign bp_upd_pc      = bp_upd_pc_q;
    assign bp_upd_taken   = bp_upd_taken_q;
    assign bp_upd_target  = bp_upd_target_q;
    assign br_count       = br_count_q;
    assign mispred_count  = mispred_count_q;
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl; narrow counters make saturation reachable.

module tb_branch_ctrl;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ex_valid = 1'b0, stall_in = 1'b0;
    logic          ex_is_br = 1'b0, ex_is_jal = 1'b0, ex_is_jalr = 1'b0;
    logic [2:0]    ex_cmpop = 3'd0;
    logic [31:0]   ex_rs1 = '0, ex_rs2 = '0, ex_pc = '0, ex_imm = '0;
    logic          ex_pred_taken = 1'b0;
    logic [31:0]   ex_pred_target = '0;
    logic          redirect_ready = 1'b0;
    logic          redirect_valid, flush, bp_upd_valid, bp_upd_taken;
    logic [31:0]   redirect_pc, bp_upd_pc, bp_upd_target;
    logic [CW-1:0] br_count, mispred_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_br = 0;

    branch_ctrl #(.CNT_W(CW), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .stall_in(stall_in),
        .ex_is_br(ex_is_br), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_cmpop(ex_cmpop), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect_ready(redirect_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .bp_upd_valid(bp_upd_valid),
        .bp_upd_pc(bp_upd_pc), .bp_upd_taken(bp_upd_taken), .bp_upd_target(bp_upd_target),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic br, input logic jal, input logic jalr, input logic [2:0] op,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pc,
                         input logic [31:0] imm, input logic pt, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_is_br = br; ex_is_jal = jal; ex_is_jalr = jalr; ex_cmpop = op;
        ex_rs1 = rs1; ex_rs2 = rs2; ex_pc = pc; ex_imm = imm;
        ex_pred_taken = pt; ex_pred_target = ptgt;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0; ex_is_br = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
    endtask

    // One line per resolved transaction plus its field checks.
    task automatic chk_upd(input string tag, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic rv, input int mis);
        $display("txn %s: pc=%0h taken=%0b target=%0h redirect=%0b rpc=%0h br=%0d mis=%0d",
                 tag, bp_upd_pc, bp_upd_taken, bp_upd_target, redirect_valid, redirect_pc,
                 br_count, mispred_count);
        chk({tag, ".upd_valid"}, {31'd0, bp_upd_valid}, 32'd1);
        chk({tag, ".upd_pc"}, bp_upd_pc, pc);
        chk({tag, ".upd_taken"}, {31'd0, bp_upd_taken}, {31'd0, tk});
        chk({tag, ".upd_target"}, bp_upd_target, tgt);
        chk({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, rv});
        chk({tag, ".br_count"}, {28'd0, br_count}, exp_br);
        chk({tag, ".mispred_count"}, {28'd0, mispred_count}, mis);
    endtask

    // Ready held high: flush stays up exactly two cycles after the redirect cycle begins.
    task automatic run_flush(input string tag);
        redirect_ready = 1'b1;
        tick();
        chk({tag, ".f1_rv"}, {31'd0, redirect_valid}, 32'd0);
        chk({tag, ".f1_flush"}, {31'd0, flush}, 32'd1);
        tick();
        chk({tag, ".f2_flush"}, {31'd0, flush}, 32'd0);
        redirect_ready = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst.rv", {31'd0, redirect_valid}, 32'd0);
        chk("rst.flush", {31'd0, flush}, 32'd0);
        chk("rst.upd", {31'd0, bp_upd_valid}, 32'd0);
        chk("rst.br", {28'd0, br_count}, 32'd0);
        chk("rst.rpc", redirect_pc, 32'd0);
        #20 rst_n = 1'b1;
        tick();

        // beq taken, correctly predicted
        drive(1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1, 32'h120);
        tick(); exp_br++; idle_ex();
        chk_upd("beq", 32'h100, 1, 32'h120, 0, 0);
        chk("beq.flush", {31'd0, flush}, 32'd0);
        tick();
        chk("beq.pulse_end", {31'd0, bp_upd_valid}, 32'd0);

        // blt signed -1 < 1 taken, predicted not taken
        drive(1, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 0, 32'h0);
        tick(); exp_br++; idle_ex();
        chk_upd("blt", 32'h200, 1, 32'h240, 1, 1);
        chk("blt.rpc", redirect_pc, 32'h240);
        chk("blt.flush", {31'd0, flush}, 32'd1);
        run_flush("blt");

        // bltu same operands: not taken, predicted taken; flush runs under stall
        drive(1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1, 32'h240);
        tick(); exp_br++; idle_ex();
        chk_upd("bltu", 32'h200, 0, 32'h240, 1, 2);
        chk("bltu.rpc", redirect_pc, 32'h204);
        stall_in = 1'b1;
        run_flush("bltu_stall");
        stall_in = 1'b0;

        // reserved cmpop 011 -> not taken, matches prediction
        drive(1, 0, 0, 3'b011, 32'd0, 32'd5, 32'h300, 32'h8, 0, 32'h308);
        tick(); exp_br++; idle_ex();
        chk_upd("rsvd011", 32'h300, 0, 32'h308, 0, 2);

        // jalr target LSB cleared, correct prediction
        drive(0, 0, 1, 3'b000, 32'h1001, 32'd0, 32'h50, 32'd2, 1, 32'h1002);
        tick(); exp_br++; idle_ex();
        chk_upd("jalr_ok", 32'h50, 1, 32'h1002, 0, 2);

        // jalr wrong target
        drive(0, 0, 1, 3'b000, 32'h1001, 32'd0, 32'h50, 32'd2, 1, 32'h1004);
        tick(); exp_br++; idle_ex();
        chk_upd("jalr_bad", 32'h50, 1, 32'h1002, 1, 3);
        chk("jalr_bad.rpc", redirect_pc, 32'h1002);
        run_flush("jalr_bad");

        // jal+br flags with unequal operands: jal wins, predicted not taken
        drive(1, 1, 0, 3'b000, 32'd1, 32'd2, 32'h400, 32'h10, 0, 32'h0);
        tick(); exp_br++;
        chk_upd("jal_hold", 32'h400, 1, 32'h410, 1, 4);
        // New mispredicting beq offered while fetch withholds ready
        drive(1, 0, 0, 3'b000, 32'd7, 32'd7, 32'h800, 32'h40, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold.rv", {31'd0, redirect_valid}, 32'd1);
            chk("hold.rpc", redirect_pc, 32'h410);
            chk("hold.flush", {31'd0, flush}, 32'd1);
            chk("hold.upd", {31'd0, bp_upd_valid}, 32'd0);
            chk("hold.br", {28'd0, br_count}, exp_br);
        end
        idle_ex();
        run_flush("hold");

        // jal+jalr flags: jalr target wins
        drive(0, 1, 1, 3'b000, 32'h600, 32'd0, 32'h500, 32'h4, 1, 32'h604);
        tick(); exp_br++; idle_ex();
        chk_upd("jalr_pri", 32'h500, 1, 32'h604, 0, 4);

        // stall blocks the resolve until released
        drive(1, 0, 0, 3'b001, 32'd1, 32'd2, 32'h700, 32'h10, 1, 32'h710);
        stall_in = 1'b1;
        tick(); tick();
        chk("stall.upd", {31'd0, bp_upd_valid}, 32'd0);
        chk("stall.br", {28'd0, br_count}, exp_br);
        stall_in = 1'b0;
        tick(); exp_br++; idle_ex();
        chk_upd("bne_unstall", 32'h700, 1, 32'h710, 0, 4);

        // saturation of br_count at all-ones
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, 3'b000, 32'd0, 32'd0, 32'h900 + 32'(4 * i), 32'h20, 1,
                  32'h920 + 32'(4 * i));
            tick();
            exp_br = (exp_br < 15) ? exp_br + 1 : 15;
            chk_upd("sat", 32'h900 + 32'(4 * i), 1, 32'h920 + 32'(4 * i), 0, 4);
        end
        idle_ex();
        tick();

        // async reset in the middle of FLUSH
        drive(0, 1, 0, 3'b000, 32'd0, 32'd0, 32'hA00, 32'h8, 0, 32'h0);
        tick(); idle_ex();
        redirect_ready = 1'b1;
        tick();
        chk("prerst.flush", {31'd0, flush}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.flush", {31'd0, flush}, 32'd0);
        chk("midrst.rv", {31'd0, redirect_valid}, 32'd0);
        chk("midrst.br", {28'd0, br_count}, 32'd0);
        chk("midrst.mis", {28'd0, mispred_count}, 32'd0);
        chk("midrst.rpc", redirect_pc, 32'd0);
        chk("midrst.upd_pc", bp_upd_pc, 32'd0);
        #2 rst_n = 1'b1;
        redirect_ready = 1'b0;
        exp_br = 0;
        tick();
        drive(1, 0, 0, 3'b101, 32'd3, 32'd3, 32'hB00, 32'h10, 1, 32'hB10);
        tick(); exp_br++; idle_ex();
        chk_upd("post_rst", 32'hB00, 1, 32'hB10, 0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
